// File: rtl/prbs7_checker.sv
// prbs7_checker
//   Serial PRBS7 (x^7 + x^6 + 1) checker. It hunts for seven bits to seed a
//   history register and then verifies a run of LOCK_GOOD correct predictions.
//   Once locked, it flywheels on its own predicted sequence, pulses err on each
//   mismatch and counts the mismatches in a saturating counter. It drops lock
//   when LOSS_BAD errors land in one 127-bit window.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   din        : received serial bit
//   din_valid  : din is sampled only when high; all state holds otherwise
//   clear_cnt  : synchronous clear of err_cnt (a coincident error yields 1)
//   locked     : high while in LOCK
//   err        : one-cycle pulse per mismatched bit while in LOCK
//   err_cnt    : saturating count of LOCK-state errors
module prbs7_checker #(
    parameter int ERR_CNT_W = 16,
    parameter int LOCK_GOOD = 16,
    parameter int LOSS_BAD  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    input  logic                 din_valid,
    input  logic                 clear_cnt,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCK   = 2'd2;

    localparam logic [7:0]           GOOD_LAST = 8'(LOCK_GOOD - 1);
    localparam logic [6:0]           BAD_LAST  = 7'(LOSS_BAD - 1);
    localparam logic [6:0]           WIN_LAST  = 7'd126;
    localparam logic [ERR_CNT_W-1:0] CNT_MAX   = {ERR_CNT_W{1'b1}};

    logic [1:0]           state_q,    state_d;
    logic [6:0]           h_q,        h_d;
    logic [2:0]           fill_cnt_q, fill_cnt_d;
    logic [7:0]           good_cnt_q, good_cnt_d;
    logic [6:0]           win_cnt_q,  win_cnt_d;
    logic [6:0]           win_err_q,  win_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;
    logic                 err_q,      err_d;
    logic                 locked_q,   locked_d;

    logic       pred;
    logic       mismatch;
    logic [6:0] h_din;
    logic       err_hit;

    always_comb begin
        pred     = h_q[6] ^ h_q[5];
        mismatch = din ^ pred;
        h_din    = {h_q[5:0], din};

        state_d    = state_q;
        h_d        = h_q;
        fill_cnt_d = fill_cnt_q;
        good_cnt_d = good_cnt_q;
        win_cnt_d  = win_cnt_q;
        win_err_d  = win_err_q;
        err_hit    = 1'b0;

        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    h_d        = h_din;
                    fill_cnt_d = fill_cnt_q + 3'd1;
                    // Seventh bit completes the history.
                    if (fill_cnt_q == 3'd6) begin
                        state_d    = ST_VERIFY;
                        good_cnt_d = 8'd0;
                    end
                end
                ST_VERIFY: begin
                    // Shifting the received bit lets the history re-align
                    // itself to the incoming phase.
                    h_d = h_din;
                    // An all-zero history predicts zeros forever, so it
                    // never counts as progress towards lock.
                    if (!mismatch && (h_din != 7'd0)) begin
                        good_cnt_d = good_cnt_q + 8'd1;
                        if (good_cnt_q == GOOD_LAST) begin
                            state_d   = ST_LOCK;
                            win_cnt_d = 7'd0;
                            win_err_d = 7'd0;
                        end
                    end else begin
                        good_cnt_d = 8'd0;
                    end
                end
                ST_LOCK: begin
                    // Flywheel: the prediction, not the received bit, feeds
                    // the history so a bit error does not propagate.
                    h_d       = {h_q[5:0], pred};
                    err_hit   = mismatch;
                    win_cnt_d = (win_cnt_q == WIN_LAST) ? 7'd0 : win_cnt_q + 7'd1;
                    if (mismatch && (win_err_q == BAD_LAST)) begin
                        state_d    = ST_HUNT;
                        fill_cnt_d = 3'd0;
                        good_cnt_d = 8'd0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        win_err_d = 7'd0;
                    end else if (mismatch) begin
                        win_err_d = win_err_q + 7'd1;
                    end
                end
                default: begin
                    state_d    = ST_HUNT;
                    fill_cnt_d = 3'd0;
                end
            endcase
        end

        err_d    = err_hit;
        locked_d = (state_d == ST_LOCK);

        // A clear that coincides with an error keeps that error.
        if (clear_cnt) begin
            err_cnt_d = ERR_CNT_W'(err_hit);
        end else if (err_hit && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            h_q        <= 7'd0;
            fill_cnt_q <= 3'd0;
            good_cnt_q <= 8'd0;
            win_cnt_q  <= 7'd0;
            win_err_q  <= 7'd0;
            err_cnt_q  <= '0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            fill_cnt_q <= fill_cnt_d;
            good_cnt_q <= good_cnt_d;
            win_cnt_q  <= win_cnt_d;
            win_err_q  <= win_err_d;
            err_cnt_q  <= err_cnt_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// tb_prbs7_checker
//   Directed bench for prbs7_checker. A default instance covers lock, flywheel,
//   loss/re-acquisition, counter clear, reset, zero stream and gapped valid.
//   A second instance with ERR_CNT_W=2 covers counter saturation.
module tb_prbs7_checker;

    logic        clk;
    logic        rst;
    logic        din;
    logic        din_valid;
    logic        clear_cnt;
    logic        locked;
    logic        err;
    logic [15:0] err_cnt;
    logic        locked2;
    logic        err2;
    logic [1:0]  err_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    logic s [0:126];
    int   pos = 0;
    int   err_seen;
    int   drops;
    int   lock_seen;
    int   first_lock;
    int   exp_sat;

    prbs7_checker dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    prbs7_checker #(.ERR_CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clear_cnt (clear_cnt),
        .locked    (locked2),
        .err       (err2),
        .err_cnt   (err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step(input logic b, input logic v);
        din       = b;
        din_valid = v;
        @(posedge clk);
        #1;
    endtask

    // One valid PRBS bit, optionally inverted.
    task automatic prbs(input logic flip);
        step(s[pos % 127] ^ flip, 1'b1);
        pos++;
    endtask

    // Clean bits, tallying err pulses and cycles without lock.
    task automatic prbs_run(input int n);
        for (int i = 0; i < n; i++) begin
            prbs(1'b0);
            err_seen += int'(err);
            drops    += int'(!locked);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic lock_from_reset(input string tag);
        for (int i = 0; i < 22; i++) prbs(1'b0);
        chk({tag, "_before_23"}, int'(locked), 0);
        prbs(1'b0);
        chk({tag, "_at_23"}, int'(locked), 1);
    endtask

    initial begin
        for (int i = 0; i < 7; i++) s[i] = 1'b1;
        for (int i = 7; i < 127; i++) s[i] = s[i-7] ^ s[i-6];

        rst       = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        clear_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_locked",  int'(locked),  0);
        chk("reset_err",     int'(err),     0);
        chk("reset_err_cnt", int'(err_cnt), 0);
        rst = 1'b0;

        // Clean lock, then 254 clean bits.
        lock_from_reset("clean_lock");
        err_seen = 0;
        drops    = 0;
        prbs_run(254);
        chk("clean_err_pulses", err_seen, 0);
        chk("clean_drops", drops, 0);
        chk("clean_err_cnt", int'(err_cnt), 0);

        // Single flipped bit: flywheel keeps lock.
        prbs(1'b1);
        chk("single_err", int'(err), 1);
        chk("single_err_cnt", int'(err_cnt), 1);
        chk("single_locked", int'(locked), 1);
        err_seen = 0;
        drops    = 0;
        prbs_run(127);
        chk("single_after_pulses", err_seen, 0);
        chk("single_after_drops", drops, 0);

        // clear_cnt alone, during a gap.
        clear_cnt = 1'b1;
        step(1'b0, 1'b0);
        clear_cnt = 1'b0;
        chk("clear_alone", int'(err_cnt), 0);
        chk("clear_gap_locked", int'(locked), 1);

        // Four errors ten bits apart inside one window.
        err_seen = 0;
        for (int k = 0; k < 4; k++) begin
            prbs(1'b1);
            err_seen += int'(err);
            if (k < 3) begin
                chk("loss_still_locked", int'(locked), 1);
                for (int i = 0; i < 9; i++) begin
                    prbs(1'b0);
                    err_seen += int'(err);
                end
            end
        end
        chk("loss_pulses", err_seen, 4);
        chk("loss_err_cnt", int'(err_cnt), 4);
        chk("loss_unlocked", int'(locked), 0);
        step(1'b1, 1'b0);
        chk("loss_gap_err", int'(err), 0);

        // Re-acquisition on the continuing clean stream.
        lock_from_reset("reacq");
        chk("reacq_err_cnt", int'(err_cnt), 4);

        // clear_cnt coincident with an error.
        clear_cnt = 1'b1;
        prbs(1'b1);
        clear_cnt = 1'b0;
        chk("clear_with_err_cnt", int'(err_cnt), 1);
        chk("clear_with_err_pulse", int'(err), 1);
        chk("clear_with_err_locked", int'(locked), 1);

        // Reset while locked.
        rst = 1'b1;
        prbs(1'b0);
        rst = 1'b0;
        chk("rst_mid_locked",  int'(locked),  0);
        chk("rst_mid_err",     int'(err),     0);
        chk("rst_mid_err_cnt", int'(err_cnt), 0);
        lock_from_reset("rst_relock");

        // All-zero stream never locks.
        do_reset();
        lock_seen = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1);
            lock_seen += int'(locked);
        end
        chk("zeros_lock", lock_seen, 0);
        chk("zeros_err_cnt", int'(err_cnt), 0);

        // Alternating valid; gap cycles carry inverted garbage.
        do_reset();
        first_lock = 0;
        err_seen   = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c % 2 == 1) begin
                prbs(1'b0);
            end else begin
                step(~s[pos % 127], 1'b0);
            end
            err_seen += int'(err);
            if (locked && (first_lock == 0)) first_lock = c + 1;
        end
        chk("gap_lock_cycle", first_lock, 46);
        chk("gap_err_pulses", err_seen, 0);

        // Saturation of a 2-bit counter, errors 130 bits apart.
        do_reset();
        chk("sat_reset_cnt", int'(err_cnt2), 0);
        lock_from_reset("sat_lock");
        drops = 0;
        for (int k = 0; k < 5; k++) begin
            prbs(1'b1);
            exp_sat = (k + 1 > 3) ? 3 : k + 1;
            chk("sat_cnt2", int'(err_cnt2), exp_sat);
            chk("sat_cnt16", int'(err_cnt), k + 1);
            step(1'b0, 1'b0);
            chk("sat_gap_err", int'(err), 0);
            err_seen = 0;
            prbs_run(129);
            chk("sat_spacing_pulses", err_seen, 0);
        end
        chk("sat_no_drop", drops, 0);
        chk("sat_locked2", int'(locked2), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
